// File: rtl/pcache_dm.sv
// Direct-mapped, write-through processor cache with one word per line.
// Read misses fill over a beat-serial system bus; writes always go through to memory.
module pcache_dm #(
    parameter int ADDR_W      = 16,
    parameter int WORD_W      = 32,
    parameter int SYS_W       = 8,
    parameter int INDEX_W     = 8,
    parameter bit WRITE_ALLOC = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pstrobe,
    input  logic              prw,
    input  logic [ADDR_W-1:0] paddress,
    input  logic [WORD_W-1:0] pdata_in,
    output logic [WORD_W-1:0] pdata_out,
    output logic              pready,
    output logic [ADDR_W-1:0] sysaddress,
    input  logic [SYS_W-1:0]  sysdata_in,
    output logic [SYS_W-1:0]  sysdata_out,
    output logic              sysrw,
    output logic              sysstrobe,
    input  logic              sysready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int OFF    = $clog2(WORD_W / 8);
    localparam int BEATS  = WORD_W / SYS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF;
    localparam int LINES  = 2 ** INDEX_W;
    localparam logic [ADDR_W-1:0] BASE_MASK  = ~ADDR_W'((1 << OFF) - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(SYS_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WMEM} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_r;
    logic                rw_r;
    logic [WORD_W-1:0]   wdata_r;
    logic [BEAT_W-1:0]   beat;
    logic [WORD_W-1:0]   fill_buf;
    logic [WORD_W-1:0]   fill_next;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_ram  [LINES];
    logic [WORD_W-1:0]   data_ram [LINES];

    logic [INDEX_W-1:0]  idx_r;
    logic [TAG_W-1:0]    tag_r;
    logic                hit;
    logic                last_beat;
    logic                ram_we;
    logic [WORD_W-1:0]   ram_wdata;

    assign idx_r     = addr_r[OFF+INDEX_W-1:OFF];
    assign tag_r     = addr_r[ADDR_W-1:OFF+INDEX_W];
    assign hit       = valid[idx_r] && (tag_ram[idx_r] == tag_r);
    assign last_beat = (beat == LAST_BEAT);

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [BEAT_W-1:0] b);
        return (a & BASE_MASK) + ADDR_W'(b) * BEAT_BYTES;
    endfunction

    function automatic logic [SYS_W-1:0] word_beat(input logic [WORD_W-1:0] w,
                                                   input logic [BEAT_W-1:0] b);
        logic [SYS_W-1:0] s;
        s = '0;
        for (int i = 0; i < BEATS; i++)
            if (b == BEAT_W'(i)) s = w[i*SYS_W +: SYS_W];
        return s;
    endfunction

    // Word being assembled, including the beat arriving this cycle
    always_comb begin
        fill_next = fill_buf;
        for (int i = 0; i < BEATS; i++)
            if (beat == BEAT_W'(i)) fill_next[i*SYS_W +: SYS_W] = sysdata_in;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = wdata_r;
        if (state == LOOKUP && !rw_r && (hit || WRITE_ALLOC)) begin
            ram_we = 1'b1;
        end else if (state == FILL && sysready && last_beat) begin
            ram_we    = 1'b1;
            ram_wdata = fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            tag_ram[idx_r]  <= tag_r;
            data_ram[idx_r] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_r      <= '0;
            rw_r        <= 1'b0;
            wdata_r     <= '0;
            beat        <= '0;
            fill_buf    <= '0;
            valid       <= '0;
            pready      <= 1'b1;
            pdata_out   <= '0;
            sysaddress  <= '0;
            sysdata_out <= '0;
            sysrw       <= 1'b0;
            sysstrobe   <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pstrobe) begin
                        addr_r  <= paddress;
                        rw_r    <= prw;
                        wdata_r <= pdata_in;
                        pready  <= 1'b0;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    beat       <= '0;
                    sysaddress <= beat_addr(addr_r, '0);
                    if (hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    end
                    if (rw_r) begin
                        if (hit) begin
                            pdata_out <= data_ram[idx_r];
                            pready    <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            sysrw     <= 1'b1;
                            sysstrobe <= 1'b1;
                            state     <= FILL;
                        end
                    end else begin
                        if (hit || WRITE_ALLOC) valid[idx_r] <= 1'b1;
                        sysrw       <= 1'b0;
                        sysstrobe   <= 1'b1;
                        sysdata_out <= word_beat(wdata_r, '0);
                        state       <= WMEM;
                    end
                end
                FILL: begin
                    if (sysready) begin
                        fill_buf <= fill_next;
                        if (last_beat) begin
                            valid[idx_r] <= 1'b1;
                            pdata_out    <= fill_next;
                            pready       <= 1'b1;
                            sysstrobe    <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            beat       <= beat + 1'b1;
                            sysaddress <= beat_addr(addr_r, beat + 1'b1);
                        end
                    end
                end
                WMEM: begin
                    if (sysready) begin
                        if (last_beat) begin
                            pready    <= 1'b1;
                            sysstrobe <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            beat        <= beat + 1'b1;
                            sysaddress  <= beat_addr(addr_r, beat + 1'b1);
                            sysdata_out <= word_beat(wdata_r, beat + 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcache_dm.sv
// Scoreboard bench for pcache_dm: an 8-bit-bus write-allocate instance and a
// 16-bit-bus no-allocate instance with 3-bit counters, each with a memory model.
module tb_pcache_dm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        pstrobe1 = 1'b0, prw1 = 1'b1;
    logic [15:0] paddr1 = '0;
    logic [31:0] pdin1 = '0, pdout1;
    logic        pready1;
    logic [15:0] saddr1;
    logic [7:0]  sdin1 = '0, sdout1;
    logic        srw1, sstb1, srdy1 = 1'b0;
    logic [15:0] hc1, mc1;

    logic        pstrobe2 = 1'b0, prw2 = 1'b1;
    logic [15:0] paddr2 = '0;
    logic [31:0] pdin2 = '0, pdout2;
    logic        pready2;
    logic [15:0] saddr2;
    logic [15:0] sdin2 = '0, sdout2;
    logic        srw2, sstb2, srdy2 = 1'b0;
    logic [2:0]  hc2, mc2;

    pcache_dm #(.ADDR_W(16), .WORD_W(32), .SYS_W(8), .INDEX_W(8),
                .WRITE_ALLOC(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .pstrobe(pstrobe1), .prw(prw1),
        .paddress(paddr1), .pdata_in(pdin1), .pdata_out(pdout1), .pready(pready1),
        .sysaddress(saddr1), .sysdata_in(sdin1), .sysdata_out(sdout1), .sysrw(srw1),
        .sysstrobe(sstb1), .sysready(srdy1), .hit_count(hc1), .miss_count(mc1));

    pcache_dm #(.ADDR_W(16), .WORD_W(32), .SYS_W(16), .INDEX_W(8),
                .WRITE_ALLOC(1'b0), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .pstrobe(pstrobe2), .prw(prw2),
        .paddress(paddr2), .pdata_in(pdin2), .pdata_out(pdout2), .pready(pready2),
        .sysaddress(saddr2), .sysdata_in(sdin2), .sysdata_out(sdout2), .sysrw(srw2),
        .sysstrobe(sstb2), .sysready(srdy2), .hit_count(hc2), .miss_count(mc2));

    typedef struct {
        int          scyc;
        bit          rd;
        logic [31:0] data;
        int          lat;
        int          hits;
        int          misses;
    } rsp_t;

    typedef struct {
        logic [15:0] addr;
        bit          rw;
        logic [31:0] data;
        int          hold;
    } beat_t;

    rsp_t  q_rsp1[$], q_rsp2[$];
    beat_t q_bt1[$],  q_bt2[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int delay1 = 0;
    bit unchk1 = 1'b0;
    int stb_seen1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // Memory + monitor for dut1: byte-wide bus with programmable wait states
    initial begin : model1
        logic [7:0]  mem1 [0:65535];
        logic [15:0] last_a;
        int          hold, wcnt;
        logic        prev_rdy;
        beat_t       b;
        rsp_t        r;
        for (int i = 0; i < 65536; i++) mem1[i] = 8'h00;
        mem1[16'h0404] = 8'h11; mem1[16'h0405] = 8'h22;
        mem1[16'h0406] = 8'h33; mem1[16'h0407] = 8'h44;
        mem1[16'h0804] = 8'h55; mem1[16'h0805] = 8'h66;
        mem1[16'h0806] = 8'h77; mem1[16'h0807] = 8'h88;
        last_a = '0; hold = 0; wcnt = 0; prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (sstb1) begin
                stb_seen1++;
                hold   = (hold > 0 && last_a == saddr1) ? hold + 1 : 1;
                last_a = saddr1;
                if (wcnt == delay1) begin
                    srdy1 = 1'b1;
                    wcnt  = 0;
                    if (srw1) sdin1 = mem1[saddr1];
                    else      mem1[saddr1] = sdout1;
                    if (!unchk1) begin
                        if (q_bt1.size() == 0) fail_now("bus1_unexpected_beat");
                        else begin
                            b = q_bt1.pop_front();
                            chk("bus1_addr", 32'(saddr1), 32'(b.addr));
                            chk("bus1_rw", 32'(srw1), 32'(b.rw));
                            chk("bus1_data", srw1 ? 32'(sdin1) : 32'(sdout1), b.data);
                            chk("bus1_hold", 32'(hold), 32'(b.hold));
                        end
                    end
                end else begin
                    srdy1 = 1'b0;
                    wcnt++;
                end
            end else begin
                srdy1 = 1'b0;
                wcnt  = 0;
                hold  = 0;
            end
            if (rst_n && pready1 && !prev_rdy) begin
                if (q_rsp1.size() == 0) fail_now("rsp1_unexpected");
                else begin
                    r = q_rsp1.pop_front();
                    chk("rsp1_latency", 32'(cyc - r.scyc), 32'(r.lat));
                    if (r.rd) chk("rsp1_pdata_out", pdout1, r.data);
                    chk("rsp1_hit_count", 32'(hc1), 32'(r.hits));
                    chk("rsp1_miss_count", 32'(mc1), 32'(r.misses));
                end
            end
            prev_rdy = pready1;
        end
    end

    // Memory + monitor for dut2: 16-bit bus, always ready
    initial begin : model2
        logic [7:0] mem2 [0:65535];
        logic       prev_rdy;
        beat_t      b;
        rsp_t       r;
        for (int i = 0; i < 65536; i++) mem2[i] = 8'h00;
        prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (sstb2) begin
                srdy2 = 1'b1;
                if (srw2) sdin2 = {mem2[saddr2 + 16'd1], mem2[saddr2]};
                else {mem2[saddr2 + 16'd1], mem2[saddr2]} = sdout2;
                if (q_bt2.size() == 0) fail_now("bus2_unexpected_beat");
                else begin
                    b = q_bt2.pop_front();
                    chk("bus2_addr", 32'(saddr2), 32'(b.addr));
                    chk("bus2_rw", 32'(srw2), 32'(b.rw));
                    chk("bus2_data", srw2 ? 32'(sdin2) : 32'(sdout2), b.data);
                end
            end else begin
                srdy2 = 1'b0;
            end
            if (rst_n && pready2 && !prev_rdy) begin
                if (q_rsp2.size() == 0) fail_now("rsp2_unexpected");
                else begin
                    r = q_rsp2.pop_front();
                    chk("rsp2_latency", 32'(cyc - r.scyc), 32'(r.lat));
                    if (r.rd) chk("rsp2_pdata_out", pdout2, r.data);
                    chk("rsp2_hit_count", 32'(hc2), 32'(r.hits));
                    chk("rsp2_miss_count", 32'(mc2), 32'(r.misses));
                end
            end
            prev_rdy = pready2;
        end
    end

    task automatic bt(input int sel, input logic [15:0] a, input bit rw,
                      input logic [31:0] d, input int hold);
        beat_t b;
        b.addr = a; b.rw = rw; b.data = d; b.hold = hold;
        if (sel == 1) q_bt1.push_back(b);
        else          q_bt2.push_back(b);
    endtask

    task automatic req(input int sel, input bit rd, input logic [15:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d,
                       input int lat, input int hits, input int misses);
        rsp_t r;
        int   n;
        @(negedge clk);
        r.scyc = cyc; r.rd = rd; r.data = exp_d; r.lat = lat;
        r.hits = hits; r.misses = misses;
        if (sel == 1) begin
            q_rsp1.push_back(r);
            pstrobe1 = 1'b1; prw1 = rd; paddr1 = a; pdin1 = wd;
        end else begin
            q_rsp2.push_back(r);
            pstrobe2 = 1'b1; prw2 = rd; paddr2 = a; pdin2 = wd;
        end
        @(negedge clk);
        pstrobe1 = 1'b0;
        pstrobe2 = 1'b0;
        n = 0;
        while (((sel == 1) ? pready1 : pready2) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("request_timeout");
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        repeat (3) @(negedge clk);
        chk("reset_pready", 32'(pready1), 32'd1);
        chk("reset_sysstrobe", 32'(sstb1), 32'd0);
        chk("reset_sysaddress", 32'(saddr1), 32'd0);
        chk("reset_pdata_out", pdout1, 32'd0);
        chk("reset_hit_count", 32'(hc1), 32'd0);
        chk("reset_miss_count", 32'(mc1), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // cold read miss, 4 beats with sysready=1
        bt(1, 16'h0404, 1'b1, 32'h11, 1); bt(1, 16'h0405, 1'b1, 32'h22, 1);
        bt(1, 16'h0406, 1'b1, 32'h33, 1); bt(1, 16'h0407, 1'b1, 32'h44, 1);
        req(1, 1'b1, 16'h0404, 32'h0, 32'h44332211, 6, 0, 1);

        // read hit, no bus traffic
        s = stb_seen1;
        req(1, 1'b1, 16'h0404, 32'h0, 32'h44332211, 2, 1, 1);
        chk("hit_no_sysstrobe", 32'(stb_seen1 - s), 32'd0);

        // write-through hit, then read back
        bt(1, 16'h0404, 1'b0, 32'hEF, 1); bt(1, 16'h0405, 1'b0, 32'hBE, 1);
        bt(1, 16'h0406, 1'b0, 32'hAD, 1); bt(1, 16'h0407, 1'b0, 32'hDE, 1);
        req(1, 1'b0, 16'h0404, 32'hDEADBEEF, 32'h0, 6, 2, 1);
        req(1, 1'b1, 16'h0404, 32'h0, 32'hDEADBEEF, 2, 3, 1);

        // conflicting tag with 3 wait cycles per beat
        delay1 = 3;
        bt(1, 16'h0804, 1'b1, 32'h55, 4); bt(1, 16'h0805, 1'b1, 32'h66, 4);
        bt(1, 16'h0806, 1'b1, 32'h77, 4); bt(1, 16'h0807, 1'b1, 32'h88, 4);
        req(1, 1'b1, 16'h0804, 32'h0, 32'h88776655, 18, 3, 2);
        delay1 = 0;
        bt(1, 16'h0404, 1'b1, 32'hEF, 1); bt(1, 16'h0405, 1'b1, 32'hBE, 1);
        bt(1, 16'h0406, 1'b1, 32'hAD, 1); bt(1, 16'h0407, 1'b1, 32'hDE, 1);
        req(1, 1'b1, 16'h0404, 32'h0, 32'hDEADBEEF, 6, 3, 3);

        // reset in the middle of a fill
        delay1 = 3;
        unchk1 = 1'b1;
        @(negedge clk);
        pstrobe1 = 1'b1; prw1 = 1'b1; paddr1 = 16'h0804;
        @(negedge clk);
        pstrobe1 = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_in_fill", 32'(sstb1), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sysstrobe", 32'(sstb1), 32'd0);
        chk("abort_pready", 32'(pready1), 32'd1);
        chk("abort_miss_count", 32'(mc1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        delay1 = 0;
        @(negedge clk);
        unchk1 = 1'b0;
        bt(1, 16'h0404, 1'b1, 32'hEF, 1); bt(1, 16'h0405, 1'b1, 32'hBE, 1);
        bt(1, 16'h0406, 1'b1, 32'hAD, 1); bt(1, 16'h0407, 1'b1, 32'hDE, 1);
        req(1, 1'b1, 16'h0404, 32'h0, 32'hDEADBEEF, 6, 0, 1);

        // no-allocate instance, 16-bit beats
        bt(2, 16'h0010, 1'b0, 32'h5678, 1); bt(2, 16'h0012, 1'b0, 32'h1234, 1);
        req(2, 1'b0, 16'h0010, 32'h12345678, 32'h0, 4, 0, 1);
        bt(2, 16'h0010, 1'b1, 32'h5678, 1); bt(2, 16'h0012, 1'b1, 32'h1234, 1);
        req(2, 1'b1, 16'h0010, 32'h0, 32'h12345678, 4, 0, 2);
        req(2, 1'b1, 16'h0010, 32'h0, 32'h12345678, 2, 1, 2);
        for (int i = 0; i < 7; i++) begin
            logic [15:0] a;
            a = 16'h0100 + 16'(i * 4);
            bt(2, a, 1'b1, 32'h0, 1);
            bt(2, a + 16'd2, 1'b1, 32'h0, 1);
            req(2, 1'b1, a, 32'h0, 32'h0, 4, 1, (i + 3 > 7) ? 7 : i + 3);
        end
        chk("sat_miss_count_final", 32'(mc2), 32'd7);

        repeat (4) @(negedge clk);
        if (q_bt1.size() != 0 || q_bt2.size() != 0) fail_now("beats_left_unseen");
        if (q_rsp1.size() != 0 || q_rsp2.size() != 0) fail_now("responses_left_unseen");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcache_dm.md
Name: pcache_dm

Overview:
- Parametrised direct-mapped, write-through processor cache. Sits between the processor port (p*) and a narrow, beat-serial system memory bus (sys*).
- Successor to the fixed 16-bit-address / 32-bit-word / byte-bus cache. Adds:
  - generic widths and depth;
  - per-line valid bits;
  - memory wait states (sysready);
  - a write-allocate mode option;
  - saturating hit/miss counters.

Parameters:
ADDR_W, 16, byte address width of paddress/sysaddress
WORD_W, 32, processor word width; multiple of SYS_W and of 8
SYS_W, 8, system bus data width; 8, 16 or 32
INDEX_W, 8, line index bits; 2**INDEX_W lines, one word per line
WRITE_ALLOC, 1, 1 = write miss installs line; 0 = write miss bypasses cache
CNT_W, 16, width of hit/miss counters
Derived: OFF = log2(WORD_W/8); BEATS = WORD_W/SYS_W; TAG_W = ADDR_W-INDEX_W-OFF; index = paddress[OFF+INDEX_W-1:OFF]; tag = paddress[ADDR_W-1:OFF+INDEX_W].

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
pstrobe  in  1  one-cycle request pulse; samples paddress/prw/pdata_in
prw  in  1  1 = read, 0 = write
paddress  in  ADDR_W  byte address; low OFF bits ignored
pdata_in  in  WORD_W  write data
pdata_out  out  WORD_W  read data; valid when pready rises after a read
pready  out  1  1 = idle/complete, 0 = busy
sysaddress  out  ADDR_W  beat byte address
sysdata_in  in  SYS_W  read beat data; valid when sysready=1
sysdata_out  out  SYS_W  write beat data
sysrw  out  1  1 = read, 0 = write
sysstrobe  out  1  burst active
sysready  in  1  memory accepts/returns the current beat
hit_count  out  CNT_W  saturating count of hits (read and write)
miss_count  out  CNT_W  saturating count of misses (read and write)

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE. All valid bits cleared; tag/data RAM contents are don't-care.
  - pready=1. pdata_out, sysaddress, sysdata_out, sysrw, sysstrobe = 0. Counters = 0.
  - Reset mid-burst aborts the burst immediately (sysstrobe=0 asynchronously) and installs nothing.
- IDLE: on pstrobe=1, register paddress/prw/pdata_in, set pready=0, go to LOOKUP. pstrobe while pready=0 is ignored.
- LOOKUP (1 cycle): hit = valid[index] && tag_ram[index]==tag.
  - Read hit: pdata_out<=data[index], pready<=1, hit_count++, go to IDLE. Total latency is 2 cycles from pstrobe to pready.
  - Read miss: miss_count++, go to FILL with beat=0.
  - Write (hit or miss): count hit/miss.
    - On a hit, or on a miss with WRITE_ALLOC=1: data[index]<=pdata_in, tag<=tag, valid<=1.
    - On a miss with WRITE_ALLOC=0: line unchanged.
    - Then go to WMEM with beat=0.
- FILL: sysrw=1, sysstrobe=1, sysaddress = word base + beat*(SYS_W/8). Word base is paddress with its low OFF bits zeroed.
  - On each cycle with sysready=1, sysdata_in is captured into bits [beat*SYS_W +: SYS_W] (little-endian), and beat++.
  - Without sysready, address and strobe hold stable indefinitely.
  - After the last beat's ack:
    - data/tag/valid written; pdata_out<=assembled word; pready<=1; sysstrobe<=0; go to IDLE.
    - This is the first cycle sysstrobe is low after the burst.
- WMEM: sysrw=0, sysstrobe=1, same address sequence; sysdata_out = pdata_in[beat*SYS_W +: SYS_W].
  - Advance on sysready.
  - After the last ack: pready<=1, sysstrobe<=0, go to IDLE. pdata_out is unchanged.
- sysaddress/sysdata_out update in the cycle after each ack. sysready is ignored while sysstrobe=0.
- Counters saturate at all-ones; no wrap.
- All cache state updates occur in a single cycle, so no partial line is ever visible on the processor port.

Test Plan:
1. Reset, then read 0x0404, with memory bytes 0x0404..0x0407 = 11,22,33,44 and sysready tied to 1:
   -> sysaddress sequence 0x0404, 0x0405, 0x0406, 0x0407 with sysrw=1;
   -> pdata_out=0x44332211 and pready=1 exactly 6 cycles after pstrobe;
   -> miss_count=1.
2. Repeat the read of 0x0404:
   -> pready=1 two cycles after pstrobe;
   -> sysstrobe stays 0;
   -> hit_count=1, pdata_out=0x44332211.
3. Write 0xDEADBEEF to 0x0404:
   -> sysrw=0 with sysdata_out EF, BE, AD, DE at 0x0404..0x0407;
   -> the next read of 0x0404 hits and returns 0xDEADBEEF.
4. Conflict and wait states: read 0x0804 (same index, new tag) with sysready delayed 3 cycles per beat:
   -> each sysaddress holds for 4 cycles;
   -> miss_count increments;
   -> a later read of 0x0404 misses again.
5. Reset asserted mid-FILL:
   -> sysstrobe drops immediately and pready=1;
   -> re-reading the previously cached 0x0404 misses, since valid bits were cleared.
6. WRITE_ALLOC=0, SYS_W=16, cold cache: write 0x12345678 to 0x0010:
   -> beats 0x5678 at 0x0010 and 0x1234 at 0x0012;
   -> the next read of 0x0010 misses;
   -> miss_count reaches all-ones and then holds when driven past its limit.
